// File: rtl/div_pkg.sv
// Shared definitions for the divide issue/retire controller: funct3 codes,
// controller state encoding and the default watchdog limit.
package div_pkg;

    // M-extension divide-class funct3 codes
    localparam logic [2:0] OpDiv  = 3'b100;
    localparam logic [2:0] OpDivu = 3'b101;
    localparam logic [2:0] OpRem  = 3'b110;
    localparam logic [2:0] OpRemu = 3'b111;

    // Divider answers after 34 cycles; the watchdog must allow more than that
    localparam int unsigned DivLatMaxDefault = 40;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2,
        StWb    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_fastpath.sv
// Combinational shortcut for divisors 0 and 1, whose results need no divider.
// Only instantiated when DIV_FASTPATH_EN is defined.
module div_fastpath
    import div_pkg::*;
(
    input  logic [2:0]  op_code_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        hit_o,
    output logic [31:0] result_o
);

    logic is_rem;

    // Divisor 0: quotient all-ones, remainder = dividend. Divisor 1: the reverse.
    always_comb begin
        is_rem   = (op_code_i == OpRem) || (op_code_i == OpRemu);
        hit_o    = 1'b0;
        result_o = '0;
        if (data2_i == 32'd0) begin
            hit_o    = 1'b1;
            result_o = is_rem ? data1_i : 32'hFFFF_FFFF;
        end else if (data2_i == 32'd1) begin
            hit_o    = 1'b1;
            result_o = is_rem ? 32'd0 : data1_i;
        end
    end

endmodule

// File: rtl/div_issue.sv
// Execute-stage issue/retire controller for DIV/DIVU/REM/REMU. Launches the
// divider, waits for its result pulse, retires through a one-cycle write port
// and discards results squashed by a flush. A watchdog flags a hung divider.
// Optional feature: define DIV_FASTPATH_EN to bypass the divider for
// divisors 0 and 1.
module div_issue
    import div_pkg::*;
#(
    parameter int unsigned DIV_LAT_MAX = DivLatMaxDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic [2:0]  ex_op_code_i,
    input  logic [31:0] ex_data1_i,
    input  logic [31:0] ex_data2_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_req_o,
    output logic [31:0] div_data1_o,
    output logic [31:0] div_data2_o,
    output logic [2:0]  div_op_code_o,
    output logic [4:0]  div_reg_wr_addr_o,
    input  logic        div_busy_i,
    input  logic        div_res_ready_i,
    input  logic [31:0] div_res_i,
    input  logic [4:0]  div_reg_wr_addr_i,
    output logic        wb_en_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        div_err_o
);

    localparam int unsigned WdW = $clog2(DIV_LAT_MAX + 1);

    div_state_e     state_q, state_d;
    logic [4:0]     rd_q, rd_d;
    logic [31:0]    res_q, res_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic [4:0]     wb_addr_q, wb_addr_d;
    logic [31:0]    wb_data_q, wb_data_d;

    logic           accept;
    logic           wd_expire;
    logic           fp_hit;
    logic [31:0]    fp_res;

`ifdef DIV_FASTPATH_EN
    div_fastpath u_fastpath (
        .op_code_i (ex_op_code_i),
        .data1_i   (ex_data1_i),
        .data2_i   (ex_data2_i),
        .hit_o     (fp_hit),
        .result_o  (fp_res)
    );
`else
    assign fp_hit = 1'b0;
    assign fp_res = '0;
`endif

    assign accept = (state_q == StIdle) && ex_div_valid_i && !flush_i && !div_busy_i;
    // wd_q counts cycles since accept; expiry is registered, so fire one cycle early
    assign wd_expire = (wd_q == WdW'(DIV_LAT_MAX - 1));

    // Next-state: issue, wait/drain for the result pulse, retire
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        res_d     = res_q;
        wd_d      = wd_q;
        err_d     = err_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rd_d = ex_rd_addr_i;
                    wd_d = WdW'(1);
                    if (fp_hit) begin
                        res_d   = fp_res;
                        state_d = StWb;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wd_d = wd_q + WdW'(1);
                if (div_res_ready_i) begin
                    if (div_reg_wr_addr_i != rd_q) begin
                        err_d = 1'b1;
                    end
                    if (flush_i) begin
                        state_d = StIdle;
                    end else begin
                        res_d   = div_res_i;
                        state_d = StWb;
                    end
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                wd_d = wd_q + WdW'(1);
                if (div_res_ready_i) begin
                    state_d = StIdle;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWb: begin
                state_d = StIdle;
                // Remember the retired write so the port holds it afterwards
                if (!flush_i) begin
                    wb_addr_d = rd_q;
                    wb_data_d = res_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_q      <= '0;
            res_q     <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            res_q     <= res_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Outputs; combinational ones are held low during reset
    always_comb begin
        stall_o           = !rst && ex_div_valid_i && (state_q != StWb) && !flush_i;
        div_req_o         = !rst && accept && !fp_hit;
        wb_en_o           = !rst && (state_q == StWb) && !flush_i;
        wb_addr_o         = rst ? 5'd0 : (wb_en_o ? rd_q : wb_addr_q);
        wb_data_o         = rst ? 32'd0 : (wb_en_o ? res_q : wb_data_q);
        div_data1_o       = rst ? 32'd0 : ex_data1_i;
        div_data2_o       = rst ? 32'd0 : ex_data2_i;
        div_op_code_o     = rst ? 3'd0 : ex_op_code_i;
        div_reg_wr_addr_o = rst ? 5'd0 : ex_rd_addr_i;
        div_err_o         = err_q;
    end

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue: a behavioural divider, an expected-write
// queue checked every cycle, and directed vectors with literal expectations.
module tb_div_issue;
    import div_pkg::*;

    localparam int LAT_MAX = 40;
`ifdef DIV_FASTPATH_EN
    localparam int FP_LAT = 1;
`else
    localparam int FP_LAT = 35;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_div_valid_i = 1'b0;
    logic [2:0]  ex_op_code_i = '0;
    logic [31:0] ex_data1_i = '0;
    logic [31:0] ex_data2_i = '0;
    logic [4:0]  ex_rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, div_req_o, wb_en_o, div_err_o;
    logic [31:0] div_data1_o, div_data2_o, wb_data_o;
    logic [2:0]  div_op_code_o;
    logic [4:0]  div_reg_wr_addr_o, wb_addr_o;
    logic        div_busy_i, div_res_ready_i;
    logic [31:0] div_res_i;
    logic [4:0]  div_reg_wr_addr_i;

    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    wb_t exp_q[$];
    wb_t cmp_e;

    logic mute = 1'b0;
    logic corrupt = 1'b0;

    div_issue #(.DIV_LAT_MAX(LAT_MAX)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_div_valid_i    (ex_div_valid_i),
        .ex_op_code_i      (ex_op_code_i),
        .ex_data1_i        (ex_data1_i),
        .ex_data2_i        (ex_data2_i),
        .ex_rd_addr_i      (ex_rd_addr_i),
        .flush_i           (flush_i),
        .stall_o           (stall_o),
        .div_req_o         (div_req_o),
        .div_data1_o       (div_data1_o),
        .div_data2_o       (div_data2_o),
        .div_op_code_o     (div_op_code_o),
        .div_reg_wr_addr_o (div_reg_wr_addr_o),
        .div_busy_i        (div_busy_i),
        .div_res_ready_i   (div_res_ready_i),
        .div_res_i         (div_res_i),
        .div_reg_wr_addr_i (div_reg_wr_addr_i),
        .wb_en_o           (wb_en_o),
        .wb_addr_o         (wb_addr_o),
        .wb_data_o         (wb_data_o),
        .div_err_o         (div_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RISC-V M-extension divide semantics
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            3'b111: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Divider model: busy for 35 cycles after a request, result pulse on the 34th
    logic        dv_active = 1'b0;
    int          dv_cnt = 0;
    logic [2:0]  dv_op = '0;
    logic [31:0] dv_a = '0;
    logic [31:0] dv_b = '0;
    logic [4:0]  dv_rd = '0;
    always @(posedge clk) begin
        if (div_req_o) begin
            dv_active <= 1'b1;
            dv_cnt    <= 0;
            dv_op     <= div_op_code_o;
            dv_a      <= div_data1_o;
            dv_b      <= div_data2_o;
            dv_rd     <= div_reg_wr_addr_o;
        end else if (dv_active) begin
            dv_cnt <= dv_cnt + 1;
            if (dv_cnt == 34 && !mute) dv_active <= 1'b0;
        end
    end
    assign div_busy_i        = dv_active;
    assign div_res_ready_i   = dv_active && (dv_cnt == 33) && !mute;
    assign div_res_i         = ref_div(dv_op, dv_a, dv_b);
    assign div_reg_wr_addr_i = dv_rd ^ {4'b0, corrupt};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Per-cycle compare against the expected-write queue and handshake rules
    always @(negedge clk) begin
        if (rst) begin
            check("rst_comb_outs", 32'({stall_o, div_req_o, wb_en_o}), 32'd0);
        end else begin
            if (!ex_div_valid_i || flush_i) check("stall_low", 32'(stall_o), 32'd0);
            else if (!wb_en_o) check("stall_high", 32'(stall_o), 32'd1);
            if (div_req_o)
                check("req_legal", 32'(ex_div_valid_i && !div_busy_i && !flush_i), 32'd1);
            check("pass_data1", div_data1_o, ex_data1_i);
            if (wb_en_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wb: actual addr %0d data %h, required no write",
                             wb_addr_o, wb_data_o);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("wb_addr_model", 32'(wb_addr_o), 32'(cmp_e.addr));
                    check("wb_data_model", wb_data_o, cmp_e.data);
                end
            end
        end
    end

    task automatic drive_ex(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        ex_div_valid_i = 1'b1;
        ex_op_code_i   = op;
        ex_data1_i     = a;
        ex_data2_i     = b;
        ex_rd_addr_i   = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name, output int c);
        c = -1;
        for (int i = 0; i < 100 && c < 0; i++) begin
            @(negedge clk);
            if (div_req_o) c = cyc;
        end
        if (c < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual no div_req_o in 100 cycles, required a request", name);
        end
    endtask

    task automatic wait_wb(input string name, output int c, output logic [31:0] d);
        c = -1;
        d = '0;
        for (int i = 0; i < 100 && c < 0; i++) begin
            @(negedge clk);
            if (wb_en_o) begin
                c = cyc;
                d = wb_data_o;
            end
        end
        if (c < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual no wb_en_o in 100 cycles, required a write", name);
        end
    endtask

    // Issue one divide, wait for its write, check value, latency and stall window
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data, input int exp_lat,
                         input string name, output int t0, output int tw);
        int pc;
        int scnt;
        logic [31:0] d;
        drive_ex(op, a, b, rd);
        exp_q.push_back('{addr: rd, data: ref_div(op, a, b)});
        pc = cyc;
        t0 = -1;
        tw = -1;
        scnt = 0;
        d = '0;
        for (int i = 0; i < 150 && tw < 0; i++) begin
            @(negedge clk);
            if (t0 < 0 && div_req_o) t0 = cyc;
            if (wb_en_o) begin
                tw = cyc;
                d = wb_data_o;
                check({name, "_stall_at_wb"}, 32'(stall_o), 32'd0);
            end else if (stall_o) begin
                scnt++;
            end
        end
        if (tw < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual no write in 150 cycles, required a write", name);
        end else begin
            if (t0 < 0) t0 = pc;
            check({name, "_data"}, d, exp_data);
            check({name, "_latency"}, 32'(tw - t0), 32'(exp_lat));
            check({name, "_stall_cycles"}, 32'(scnt), 32'(tw - pc));
        end
        tick();
        ex_div_valid_i = 1'b0;
    endtask

    initial begin
        int t0, t1, tw, ta, tb, te;
        logic [31:0] d;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_req", 32'(div_req_o), 32'd0);
        check("reset_wb_en", 32'(wb_en_o), 32'd0);
        check("reset_err", 32'(div_err_o), 32'd0);
        check("reset_wb_addr", 32'(wb_addr_o), 32'd0);
        check("reset_wb_data", wb_data_o, 32'd0);

        // Pin the model against hand-computed values
        check("model_divu", ref_div(OpDivu, 32'd100, 32'd7), 32'd14);
        check("model_div_ovf", ref_div(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("model_rem_neg", ref_div(OpRem, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        tick();
        do_op(OpDivu, 32'd100, 32'd7, 5'd5, 32'd14, 35, "divu_100_7", ta, tw);
        check("divu_wb_addr", 32'(wb_addr_o), 32'd5);
        do_op(OpRem, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 35, "rem_neg7_2", tb, tw);
        check("back_to_back_accept", 32'(tb), 32'(ta + 36));
        do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, 35, "div_ovf", ta, tw);
        do_op(OpDiv, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, FP_LAT, "div_by_0", ta, tw);
        do_op(OpRemu, 32'd5, 32'd1, 5'd12, 32'd0, FP_LAT, "remu_by_1", ta, tw);
        do_op(OpRem, 32'd5, 32'd0, 5'd13, 32'd5, FP_LAT, "rem_by_0", ta, tw);

        // Flush in WAIT: result drained, next divide waits for the divider
        drive_ex(OpDivu, 32'd1000, 32'd10, 5'd3);
        wait_req("flush_first_req", t0);
        while (cyc < t0 + 10) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive_ex(OpDivu, 32'd9, 32'd3, 5'd6);
        exp_q.push_back('{addr: 5'd6, data: 32'd3});
        wait_req("flush_second_req", t1);
        check("flush_reaccept_cycle", 32'(t1), 32'(t0 + 36));
        wait_wb("flush_second_wb", tw, d);
        check("flush_second_data", d, 32'd3);
        check("flush_second_latency", 32'(tw - t1), 32'd35);
        tick();
        ex_div_valid_i = 1'b0;

        // Reset mid-operation: late ready ignored, new request waits for busy=0
        drive_ex(OpDivu, 32'd1000, 32'd10, 5'd7);
        wait_req("rst_first_req", t0);
        while (cyc < t0 + 20) tick();
        rst = 1'b1;
        drive_ex(OpDivu, 32'd8, 32'd2, 5'd8);
        exp_q.push_back('{addr: 5'd8, data: 32'd4});
        tick();
        rst = 1'b0;
        wait_req("rst_second_req", t1);
        check("rst_reaccept_cycle", 32'(t1), 32'(t0 + 36));
        wait_wb("rst_second_wb", tw, d);
        check("rst_second_data", d, 32'd4);
        tick();
        ex_div_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_wb_en", 32'(wb_en_o), 32'd0);
        check("hold_wb_addr", 32'(wb_addr_o), 32'd8);
        check("hold_wb_data", wb_data_o, 32'd4);

        // Divider reports a different rd: still retired, error flagged
        tick();
        corrupt = 1'b1;
        check("err_before_mismatch", 32'(div_err_o), 32'd0);
        do_op(OpDivu, 32'd20, 32'd4, 5'd10, 32'd5, 35, "rd_mismatch", ta, tw);
        check("err_after_mismatch", 32'(div_err_o), 32'd1);
        corrupt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("err_cleared_by_rst", 32'(div_err_o), 32'd0);
        check("wb_data_cleared_by_rst", wb_data_o, 32'd0);

        // Divider never answers: watchdog flags error, no write
        tick();
        mute = 1'b1;
        drive_ex(OpDivu, 32'd50, 32'd5, 5'd9);
        wait_req("wd_req", t0);
        te = -1;
        for (int i = 0; i < 60 && te < 0; i++) begin
            @(negedge clk);
            if (div_err_o) te = cyc;
        end
        check("wd_err_cycle", 32'(te), 32'(t0 + LAT_MAX));
        tick();
        ex_div_valid_i = 1'b0;
        @(negedge clk);
        check("wd_stall_dropped", 32'(stall_o), 32'd0);
        check("wd_no_new_req", 32'(div_req_o), 32'd0);
        check("wd_err_sticky", 32'(div_err_o), 32'd1);

        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: actual time limit reached, required $finish");
        $fatal(1);
    end

endmodule
